// File: rtl/mealy_timed_traffic_ctrl.sv
// Two-way traffic-light controller with a pedestrian phase and a per-state cycle timer.
// The transition (phase_done) is Mealy; lights follow the state, optionally through one register stage.
module mealy_timed_traffic_ctrl #(
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 3,
    parameter int T_CLEAR  = 2,
    parameter int T_WALK   = 6,
    parameter int TW       = 8,
    parameter int REG_OUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    input  logic       hold,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk,
    output logic       phase_done,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR1    = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR2    = 3'd5,
        WALK      = 3'd6,
        ILLEGAL   = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Last timer value of each state: a state lasts T cycles when t reaches T-1.
    localparam logic [TW-1:0] G_LAST = TW'(T_GREEN - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] C_LAST = TW'(T_CLEAR - 1);
    localparam logic [TW-1:0] W_LAST = TW'(T_WALK - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] t;
    logic          ped_pending;
    logic          take;
    logic [2:0]    ns_c;
    logic [2:0]    ew_c;
    logic          walk_c;
    logic          done_c;

    function automatic logic expired(input logic [TW-1:0] tv, input logic [TW-1:0] last);
        return tv >= last;
    endfunction

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        if (!hold) begin
            case (state)
                NS_GREEN:  if (expired(t, G_LAST) && (car_ew || ped_pending)) begin
                               state_nxt = NS_YELLOW; take = 1'b1;
                           end
                NS_YELLOW: if (expired(t, Y_LAST)) begin state_nxt = CLEAR1; take = 1'b1; end
                CLEAR1:    if (expired(t, C_LAST)) begin state_nxt = EW_GREEN; take = 1'b1; end
                EW_GREEN:  if (expired(t, G_LAST) && (car_ns || ped_pending)) begin
                               state_nxt = EW_YELLOW; take = 1'b1;
                           end
                EW_YELLOW: if (expired(t, Y_LAST)) begin state_nxt = CLEAR2; take = 1'b1; end
                CLEAR2:    if (expired(t, C_LAST)) begin
                               state_nxt = ped_pending ? WALK : NS_GREEN; take = 1'b1;
                           end
                WALK:      if (expired(t, W_LAST)) begin state_nxt = NS_GREEN; take = 1'b1; end
                default:   ;
            endcase
        end
        // The unused code recovers even while frozen.
        if (state == ILLEGAL) state_nxt = NS_GREEN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= NS_GREEN;
            t           <= '0;
            ped_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                t <= '0;
            else if (!hold && (t != '1))
                t <= t + 1'b1;
            if ((state_nxt == WALK) && (state != WALK))
                ped_pending <= 1'b0;
            else if (ped_req && (state != WALK))
                ped_pending <= 1'b1;
        end
    end

    always_comb begin
        ns_c   = RED;
        ew_c   = RED;
        walk_c = 1'b0;
        case (state)
            NS_GREEN:  ns_c   = GRN;
            NS_YELLOW: ns_c   = YEL;
            EW_GREEN:  ew_c   = GRN;
            EW_YELLOW: ew_c   = YEL;
            WALK:      walk_c = 1'b1;
            default:   ;
        endcase
        done_c = take & ~reset;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    light_ns   <= RED;
                    light_ew   <= RED;
                    walk       <= 1'b0;
                    phase_done <= 1'b0;
                end else begin
                    light_ns   <= ns_c;
                    light_ew   <= ew_c;
                    walk       <= walk_c;
                    phase_done <= done_c;
                end
            end
        end else begin : g_comb_out
            assign light_ns   = ns_c;
            assign light_ew   = ew_c;
            assign walk       = walk_c;
            assign phase_done = done_c;
        end
    endgenerate

    assign state_out = state;

endmodule

// File: tb/tb_mealy_timed_traffic_ctrl.sv
// Scoreboarded bench: a phase/duration reference model predicts both output variants per cycle,
// a negedge monitor pops and compares them against a combinational and a registered-output instance.
module tb_mealy_timed_traffic_ctrl;

    logic clk = 1'b0;
    logic rst, car_ns, car_ew, ped_req, hold;
    logic [2:0] ns0, ew0, st0, ns1, ew1, st1;
    logic walk0, pd0, walk1, pd1;

    always #5 clk = ~clk;

    mealy_timed_traffic_ctrl #(.REG_OUT(0)) dut0 (
        .clk(clk), .reset(rst), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
        .hold(hold), .light_ns(ns0), .light_ew(ew0), .walk(walk0), .phase_done(pd0),
        .state_out(st0));

    mealy_timed_traffic_ctrl #(.REG_OUT(1)) dut1 (
        .clk(clk), .reset(rst), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
        .hold(hold), .light_ns(ns1), .light_ew(ew1), .walk(walk1), .phase_done(pd1),
        .state_out(st1));

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       pd;
        logic [2:0] st;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: phase index, cycles spent in phase (excluding held cycles), pending walk.
    int   dur[7] = '{8, 3, 2, 8, 3, 2, 6};
    int   p = 0;
    int   e = 0;
    bit   pend = 1'b0;
    obs_t prev0;
    bit   prev_rst = 1'b1;

    function automatic bit model_take();
        bit demand;
        demand = 1'b1;
        if (p == 0) demand = car_ew || pend;
        if (p == 3) demand = car_ns || pend;
        return !hold && (e >= dur[p] - 1) && demand;
    endfunction

    function automatic obs_t model_lights(bit r);
        obs_t o;
        o.ns   = (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
        o.ew   = (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
        o.walk = (p == 6);
        o.pd   = !r && model_take();
        o.st   = 3'(p);
        return o;
    endfunction

    task automatic step(input bit r, input bit cns, input bit cew, input bit ped, input bit hld);
        obs_t o0, o1;
        int   np;
        bit   tk;
        rst = r; car_ns = cns; car_ew = cew; ped_req = ped; hold = hld;
        if (r) begin
            p = 0; e = 0; pend = 1'b0;
        end
        o0 = model_lights(r);
        if (r || prev_rst) o1 = '{ns: 3'b100, ew: 3'b100, walk: 1'b0, pd: 1'b0, st: 3'(p)};
        else               o1 = '{ns: prev0.ns, ew: prev0.ew, walk: prev0.walk, pd: prev0.pd, st: 3'(p)};
        q0.push_back(o0);
        q1.push_back(o1);
        prev0    = o0;
        prev_rst = r;
        @(posedge clk);
        if (!r) begin
            tk = model_take();
            np = p;
            if (tk) begin
                case (p)
                    5:       np = pend ? 6 : 0;
                    6:       np = 0;
                    default: np = p + 1;
                endcase
            end
            if (np == 6 && p != 6) pend = 1'b0;
            else if (ped && p != 6) pend = 1'b1;
            e = tk ? 0 : (hld ? e : e + 1);
            p = np;
        end
        #1;
        cyc++;
    endtask

    task automatic cmp(input string nm, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t o;
        if (q0.size() > 0) begin
            o = q0.pop_front();
            cmp("dut0.light_ns", ns0, o.ns);
            cmp("dut0.light_ew", ew0, o.ew);
            cmp("dut0.walk", {2'b0, walk0}, {2'b0, o.walk});
            cmp("dut0.phase_done", {2'b0, pd0}, {2'b0, o.pd});
            cmp("dut0.state_out", st0, o.st);
        end
        if (q1.size() > 0) begin
            o = q1.pop_front();
            cmp("dut1.light_ns", ns1, o.ns);
            cmp("dut1.light_ew", ew1, o.ew);
            cmp("dut1.walk", {2'b0, walk1}, {2'b0, o.walk});
            cmp("dut1.phase_done", {2'b0, pd1}, {2'b0, o.pd});
            cmp("dut1.state_out", st1, o.st);
        end
    end

    initial begin
        rst = 1'b1; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1, 0, 0, 0, 0);
        // Long idle: no demand, the controller must stay in NS_GREEN.
        repeat (300) step(0, 0, 0, 0, 0);
        // Steady east-west demand from reset release.
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (40) step(0, 0, 1, 0, 0);
        // Pedestrian pulse during EW_GREEN leads to a walk phase after CLEAR2.
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (15) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (40) step(0, 0, 0, 0, 0);
        // Hold for five cycles starting at the second yellow cycle.
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (9) step(0, 0, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 1);
        repeat (20) step(0, 0, 1, 0, 0);
        // Reset mid-EW_GREEN with a pending walk request.
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (14) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (30) step(0, 1, 0, 0, 0);
        // Randomized traffic, holds, requests and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 9) == 0));
        end
        // Pedestrian request held high across walk entry and walk phases.
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, ($urandom_range(0, 19) == 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d/%0d entries left expected=0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealy_timed_traffic_ctrl.md
MEALY_TIMED_TRAFFIC_CTRL -- requirements
Module: mealy_timed_traffic_ctrl

Interface
REQ-001 Parameter T_GREEN, default 8: minimum green duration in clock cycles, >=1.
REQ-002 Parameter T_YELLOW, default 3: yellow duration in clock cycles, >=1.
REQ-003 Parameter T_CLEAR, default 2: all-red clearance duration in clock cycles, >=1.
REQ-004 Parameter T_WALK, default 6: pedestrian walk duration in clock cycles, >=1.
REQ-005 Parameter TW, default 8: timer width in bits; every T_* value SHALL be <= 2^TW.
REQ-006 Parameter REG_OUT, default 0: 0 gives combinational Mealy outputs; 1 gives outputs through one D-FF stage.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 car_ns  input  1  level sensor for north-south vehicle demand.
REQ-010 car_ew  input  1  level sensor for east-west vehicle demand.
REQ-011 ped_req  input  1  pedestrian request; a single-cycle pulse is sufficient.
REQ-012 hold  input  1  freezes the timer and all transitions while high.
REQ-013 light_ns  output  3  {red,yellow,green}, one-hot.
REQ-014 light_ew  output  3  {red,yellow,green}, one-hot.
REQ-015 walk  output  1  pedestrian walk indication.
REQ-016 phase_done  output  1  Mealy pulse; high in the cycle a state transition is taken.
REQ-017 state_out  output  3  current state code, for debug.

Function
REQ-018 States and codes: NS_GREEN=0, NS_YELLOW=1, CLEAR1=2, EW_GREEN=3, EW_YELLOW=4, CLEAR2=5, WALK=6; code 7 is illegal and SHALL go to NS_GREEN on the next edge.
REQ-019 Timer t (TW bits) SHALL clear to 0 on any edge where state changes, hold at its value while hold=1, and otherwise increment, saturating at all-ones.
REQ-020 "Expired(T)" means t >= T-1, so an undelayed state lasts exactly T cycles.
REQ-021 NS_GREEN to NS_YELLOW when Expired(T_GREEN) and (car_ew or ped_pending); otherwise remain in NS_GREEN.
REQ-022 NS_YELLOW to CLEAR1 when Expired(T_YELLOW); CLEAR1 to EW_GREEN when Expired(T_CLEAR).
REQ-023 EW_GREEN to EW_YELLOW when Expired(T_GREEN) and (car_ns or ped_pending); otherwise remain in EW_GREEN.
REQ-024 EW_YELLOW to CLEAR2 when Expired(T_YELLOW).
REQ-025 CLEAR2 to WALK when Expired(T_CLEAR) and ped_pending; otherwise to NS_GREEN when Expired(T_CLEAR).
REQ-026 WALK to NS_GREEN when Expired(T_WALK).
REQ-027 While hold=1, no transition SHALL be taken and phase_done SHALL be 0.
REQ-028 ped_pending SHALL set on ped_req=1 in any state except WALK, and SHALL clear on the edge entering WALK; on that entry edge clear wins over a simultaneous ped_req.
REQ-029 ped_req while in WALK SHALL be ignored.
REQ-030 Light encoding: both lights red (100) in CLEAR1, CLEAR2 and WALK.
  - NS_GREEN: light_ns green (001).
  - NS_YELLOW: light_ns yellow (010).
  - EW_GREEN and EW_YELLOW: light_ew green and yellow respectively.
  - The idle direction SHALL show red in every state.
REQ-031 walk SHALL be 1 only in WALK.
REQ-032 phase_done SHALL be combinational from state, t, inputs and ped_pending.
REQ-033 With REG_OUT=1, all outputs SHALL be delayed by exactly one cycle relative to REG_OUT=0; state_out SHALL remain unregistered.

Reset
REQ-034 reset SHALL asynchronously force state NS_GREEN, t=0 and ped_pending=0.
REQ-035 Output values while reset is asserted, including reset applied mid-operation:
  - REG_OUT=0: light_ns=001, light_ew=100, walk=0, phase_done=0.
  - REG_OUT=1: light_ns=100, light_ew=100, walk=0, phase_done=0, until the first edge after reset is released.

Verification
REQ-036 Defaults, no demand for 300 cycles -> state stays NS_GREEN, t saturates at 255, phase_done never pulses.
REQ-037 car_ew held at 1 from reset release (cycle 0) -> phase_done=1 at cycles 7, 10 and 12; EW_GREEN entered at cycle 13.
REQ-038 ped_req 1-cycle pulse during EW_GREEN, car_ns=0 -> after CLEAR2, WALK with walk=1 for 6 cycles, then NS_GREEN; ped_pending=0 afterwards.
REQ-039 hold=1 for 5 cycles starting at NS_YELLOW cycle 1 -> yellow lasts 8 cycles in total; no phase_done while hold=1.
REQ-040 reset pulse mid-EW_GREEN with ped_pending=1 -> immediate NS_GREEN outputs (REG_OUT=0), ped_pending=0, and no WALK in the following cycle.
REQ-041 Rerun REQ-037 with REG_OUT=1 -> every output transition occurs exactly one cycle later; outputs are all-red during reset.
